// File: rtl/counter_checker.sv
// counter_checker: watches the count bus of a free-running up-counter and
// verifies that every sample is the previous sample + 1 (mod 2^WIDTH).
// Lock is gained after LOCK_LEN consecutive good increments. While locked,
// a break is reported as a restart (jump to 0) or as an error. Correct
// max->0 transitions are reported as wraps.
module counter_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int               RUN_W     = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK  = RUN_W'(LOCK_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [WIDTH-1:0] WIDTH_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] WIDTH_MAX = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_inc;
  logic             inc_ok;
  logic             err_nxt, restart_nxt, wrap_nxt;
  logic [CNT_W-1:0] err_count_nxt, wrap_count_nxt;

  // Error counter sticks at all-ones so a long-running monitor never aliases.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  assign prev_inc = prev + WIDTH_ONE;
  assign inc_ok   = (count_in == prev_inc);
  assign locked   = (state == LOCKED);

  // State, history and all reported outputs update together on each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      run           <= '0;
      prev          <= '0;
      expected      <= '0;
      err_pulse     <= 1'b0;
      restart_pulse <= 1'b0;
      wrap_pulse    <= 1'b0;
      err_count     <= '0;
      wrap_count    <= '0;
    end else begin
      state         <= state_nxt;
      run           <= run_nxt;
      prev          <= count_in;
      expected      <= count_in + WIDTH_ONE;
      err_pulse     <= err_nxt;
      restart_pulse <= restart_nxt;
      wrap_pulse    <= wrap_nxt;
      err_count     <= err_count_nxt;
      wrap_count    <= wrap_count_nxt;
    end
  end

  // Classify the current sample against the previous one and pick the next state.
  always_comb begin
    state_nxt      = state;
    run_nxt        = run;
    err_nxt        = 1'b0;
    restart_nxt    = 1'b0;
    wrap_nxt       = 1'b0;
    err_count_nxt  = err_count;
    wrap_count_nxt = wrap_count;
    case (state)
      EMPTY: begin
        state_nxt = ACQUIRE;
        run_nxt   = '0;
      end
      ACQUIRE: begin
        if (inc_ok) begin
          run_nxt = run + RUN_ONE;
          if (run + RUN_ONE == RUN_LOCK) begin
            state_nxt = LOCKED;
            run_nxt   = '0;
          end
        end else begin
          run_nxt = '0;
        end
      end
      LOCKED: begin
        if (inc_ok) begin
          // A good increment out of the top value is a wrap.
          if (prev == WIDTH_MAX) begin
            wrap_nxt       = 1'b1;
            wrap_count_nxt = wrap_count + CNT_ONE;
          end
        end else if (count_in == '0) begin
          restart_nxt = 1'b1;
          state_nxt   = ACQUIRE;
          run_nxt     = '0;
        end else begin
          err_nxt       = 1'b1;
          err_count_nxt = sat_inc(err_count);
          state_nxt     = ACQUIRE;
          run_nxt       = '0;
        end
      end
      default: begin
        state_nxt = EMPTY;
        run_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: table-driven vectors on a default instance
// (LOCK_LEN=4, CNT_W=16) and a small instance (LOCK_LEN=1, CNT_W=2) that
// reaches counter saturation quickly, plus an asynchronous reset sequence.
module tb_counter_checker;

  logic        clk;
  logic        rst;
  logic [7:0]  count_in;
  logic        locked;
  logic [7:0]  expected;
  logic        err_pulse, restart_pulse, wrap_pulse;
  logic [15:0] err_count, wrap_count;

  logic [7:0]  count_in2;
  logic        locked2;
  logic [7:0]  expected2;
  logic        err_pulse2, restart_pulse2, wrap_pulse2;
  logic [1:0]  err_count2, wrap_count2;

  int checks = 0;
  int errors = 0;

  counter_checker #(.WIDTH(8), .LOCK_LEN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .locked(locked),
    .expected(expected), .err_pulse(err_pulse), .restart_pulse(restart_pulse),
    .wrap_pulse(wrap_pulse), .err_count(err_count), .wrap_count(wrap_count)
  );

  counter_checker #(.WIDTH(8), .LOCK_LEN(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in2), .locked(locked2),
    .expected(expected2), .err_pulse(err_pulse2), .restart_pulse(restart_pulse2),
    .wrap_pulse(wrap_pulse2), .err_count(err_count2), .wrap_count(wrap_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  cin;
    logic        lk;
    logic [7:0]  ex;
    logic        e;
    logic        r;
    logic        w;
    logic [15:0] ec;
    logic [15:0] wc;
  } vec_t;

  vec_t tab1[$];
  vec_t tab1b[$];
  vec_t tab2[$];

  function automatic vec_t mk(int r, int c, int l, int x, int e, int rs, int w, int ec, int wc);
    vec_t v;
    v.rst = r[0];  v.cin = c[7:0]; v.lk = l[0]; v.ex = x[7:0];
    v.e = e[0];    v.r = rs[0];    v.w = w[0];  v.ec = ec[15:0]; v.wc = wc[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %0d want %0d", nm, idx, act, req);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input vec_t v, input bit d2);
    if (!d2) begin
      chk({tag, ".locked"},   idx, 32'(locked),        32'(v.lk));
      chk({tag, ".expected"}, idx, 32'(expected),      32'(v.ex));
      chk({tag, ".err"},      idx, 32'(err_pulse),     32'(v.e));
      chk({tag, ".restart"},  idx, 32'(restart_pulse), 32'(v.r));
      chk({tag, ".wrap"},     idx, 32'(wrap_pulse),    32'(v.w));
      chk({tag, ".err_cnt"},  idx, 32'(err_count),     32'(v.ec));
      chk({tag, ".wrap_cnt"}, idx, 32'(wrap_count),    32'(v.wc));
    end else begin
      chk({tag, ".locked"},   idx, 32'(locked2),        32'(v.lk));
      chk({tag, ".expected"}, idx, 32'(expected2),      32'(v.ex));
      chk({tag, ".err"},      idx, 32'(err_pulse2),     32'(v.e));
      chk({tag, ".restart"},  idx, 32'(restart_pulse2), 32'(v.r));
      chk({tag, ".wrap"},     idx, 32'(wrap_pulse2),    32'(v.w));
      chk({tag, ".err_cnt"},  idx, 32'(err_count2),     32'(v.ec));
      chk({tag, ".wrap_cnt"}, idx, 32'(wrap_count2),    32'(v.wc));
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input string tag, input int idx, input vec_t v, input bit d2);
    @(negedge clk);
    rst = v.rst;
    if (d2) count_in2 = v.cin;
    else    count_in  = v.cin;
    @(posedge clk);
    #1;
    check_outs(tag, idx, v, d2);
  endtask

  initial begin
    vec_t z;
    rst = 1'b1;
    count_in = 8'd0;
    count_in2 = 8'd0;

    //            rst cin  lk  exp  e  r  w  ec wc
    // Acquire from reset: lock on the 5th sample.
    tab1.push_back(mk(0,   0, 0,   1, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,   1, 0,   2, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,   2, 0,   3, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,   3, 0,   4, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,   4, 1,   5, 0, 0, 0, 0, 0));
    // Wrap while locked.
    tab1.push_back(mk(1,   9, 0,   0, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 249, 0, 250, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 250, 0, 251, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 251, 0, 252, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 252, 0, 253, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 253, 1, 254, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 254, 1, 255, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0, 255, 1,   0, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,   0, 1,   1, 0, 0, 1, 0, 1));
    tab1.push_back(mk(0,   1, 1,   2, 0, 0, 0, 0, 1));
    // Skip while locked, then relock.
    tab1.push_back(mk(1,   0, 0,   0, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  36, 0,  37, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  37, 0,  38, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  38, 0,  39, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  39, 0,  40, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  40, 1,  41, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  41, 1,  42, 0, 0, 0, 0, 0));
    tab1.push_back(mk(0,  43, 0,  44, 1, 0, 0, 1, 0));
    tab1.push_back(mk(0,  44, 0,  45, 0, 0, 0, 1, 0));
    tab1.push_back(mk(0,  45, 0,  46, 0, 0, 0, 1, 0));
    tab1.push_back(mk(0,  46, 0,  47, 0, 0, 0, 1, 0));
    tab1.push_back(mk(0,  47, 1,  48, 0, 0, 0, 1, 0));
    // Jump to 96 (error), relock at 100, then counter restart to 0.
    tab1.push_back(mk(0,  96, 0,  97, 1, 0, 0, 2, 0));
    tab1.push_back(mk(0,  97, 0,  98, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,  98, 0,  99, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,  99, 0, 100, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0, 100, 1, 101, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   0, 0,   1, 0, 1, 0, 2, 0));
    tab1.push_back(mk(0,   1, 0,   2, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   2, 0,   3, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   3, 0,   4, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   4, 1,   5, 0, 0, 0, 2, 0));
    // Held value: one error, then silence in ACQUIRE; relock at 11.
    tab1.push_back(mk(0,   5, 1,   6, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   6, 1,   7, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   7, 1,   8, 0, 0, 0, 2, 0));
    tab1.push_back(mk(0,   7, 0,   8, 1, 0, 0, 3, 0));
    tab1.push_back(mk(0,   7, 0,   8, 0, 0, 0, 3, 0));
    tab1.push_back(mk(0,   8, 0,   9, 0, 0, 0, 3, 0));
    tab1.push_back(mk(0,   9, 0,  10, 0, 0, 0, 3, 0));
    tab1.push_back(mk(0,  10, 0,  11, 0, 0, 0, 3, 0));
    tab1.push_back(mk(0,  11, 1,  12, 0, 0, 0, 3, 0));
    // After asynchronous reset: first samples are not errors.
    tab1b.push_back(mk(0, 50, 0,  51, 0, 0, 0, 0, 0));
    tab1b.push_back(mk(0, 51, 0,  52, 0, 0, 0, 0, 0));

    // LOCK_LEN=1, CNT_W=2 instance: quick lock, saturation, wrap cases.
    tab2.push_back(mk(1,   0, 0,   0, 0, 0, 0, 0, 0));
    tab2.push_back(mk(0,  10, 0,  11, 0, 0, 0, 0, 0));
    tab2.push_back(mk(0,  11, 1,  12, 0, 0, 0, 0, 0));
    tab2.push_back(mk(0,  13, 0,  14, 1, 0, 0, 1, 0));
    tab2.push_back(mk(0,  14, 1,  15, 0, 0, 0, 1, 0));
    tab2.push_back(mk(0,  16, 0,  17, 1, 0, 0, 2, 0));
    tab2.push_back(mk(0,  17, 1,  18, 0, 0, 0, 2, 0));
    tab2.push_back(mk(0,  19, 0,  20, 1, 0, 0, 3, 0));
    tab2.push_back(mk(0,  20, 1,  21, 0, 0, 0, 3, 0));
    tab2.push_back(mk(0,  22, 0,  23, 1, 0, 0, 3, 0));
    tab2.push_back(mk(0, 254, 0, 255, 0, 0, 0, 3, 0));
    tab2.push_back(mk(0, 255, 1,   0, 0, 0, 0, 3, 0));
    tab2.push_back(mk(0,   1, 0,   2, 1, 0, 0, 3, 0));
    tab2.push_back(mk(0, 254, 0, 255, 0, 0, 0, 3, 0));
    tab2.push_back(mk(0, 255, 1,   0, 0, 0, 0, 3, 0));
    tab2.push_back(mk(0,   0, 1,   1, 0, 0, 1, 3, 1));

    // Reset state before any clock edge.
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_outs("reset", 0, z, 1'b0);
    check_outs("reset2", 0, z, 1'b1);

    foreach (tab1[i]) apply("main", i, tab1[i], 1'b0);

    // Asynchronous reset between edges with err_count=3 and locked=1.
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, z, 1'b0);

    foreach (tab1b[i]) apply("post_rst", i, tab1b[i], 1'b0);

    foreach (tab2[i]) apply("lock1", i, tab2[i], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
